// File: rtl/mgee3_div_pkg.sv
// Shared constants, FSM encoding and pin payload layouts for the 3-bit divider.
package mgee3_div_pkg;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned CNT_W = 2;

  // Quotient reported when the divisor is zero
  localparam logic [WIDTH-1:0] DBZ_QUOT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             spare;
    logic             start;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividend;
  } pins_in_t;

  typedef struct packed {
    logic             div_by_zero;
    logic             done;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
  } pins_out_t;

endpackage

// File: rtl/mgee3_divider_div_step.sv
// One restoring-division step: compare/subtract the trial value against the divisor.
module div_step
  import mgee3_div_pkg::*;
(
  input  logic [WIDTH:0]   trial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  // Top bit of diff is the borrow-out of the (WIDTH+1)-bit subtraction
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_hi;

  assign diff     = {1'b0, trial} - {2'b00, divisor};
  assign borrow   = diff[WIDTH+1];
  assign quot_bit = ~borrow;

  // Either result is below the divisor, so the top bit is always zero
  assign rem_next  = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign unused_hi = trial[WIDTH] ^ diff[WIDTH];

endmodule

// File: rtl/mgee3_divider.sv
// Sequential 3-bit unsigned restoring divider behind the tapeout io_in/io_out pins.
module mgee3_divider
  import mgee3_div_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  pins_in_t  pins;
  pins_out_t outs;
  logic      unused_spare;

  state_t           state_q, state_d;
  logic             start_q;
  logic             start_edge;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic             b_zero;

  assign pins         = pins_in_t'(io_in);
  assign unused_spare = pins.spare;
  assign start_edge   = pins.start & ~start_q;
  assign b_zero       = (b_q == '0);

  // Dividend bits are consumed MSB-first from the shifting operand register
  div_step u_step (
    .trial    ({rem_q, a_q[WIDTH-1]}),
    .divisor  (b_q),
    .rem_next (step_rem),
    .quot_bit (step_bit)
  );

  // State register and start edge detector
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      start_q <= pins.start;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_edge) state_d = RUN;
      RUN:        if (b_zero || (cnt_q == '0)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and status next values
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          a_d    = pins.dividend;
          b_d    = pins.divisor;
          rem_d  = '0;
          quot_d = '0;
          cnt_d  = CNT_W'(WIDTH - 1);
          done_d = 1'b0;
          dbz_d  = 1'b0;
        end
      end
      RUN: begin
        if (b_zero) begin
          quot_d = DBZ_QUOT;
          rem_d  = a_q;
          cnt_d  = '0;
          done_d = 1'b1;
          dbz_d  = 1'b1;
        end else begin
          rem_d  = step_rem;
          quot_d = {quot_q[WIDTH-2:0], step_bit};
          a_d    = {a_q[WIDTH-2:0], 1'b0};
          if (cnt_q == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  assign outs = '{div_by_zero: dbz_q, done: done_q, rem: rem_q, quot: quot_q};
  assign io_out = outs;

endmodule

// File: tb/tb_mgee3_divider.sv
// Scoreboard bench for mgee3_divider: results are queued at launch and checked when done rises.
module tb_mgee3_divider;

  logic       clock;
  logic       reset;
  logic [7:0] io_in;
  logic [7:0] io_out;

  typedef struct {
    int q;
    int r;
    int dbz;
    int lat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic done_prev = 1'b0;

  mgee3_divider dut (
    .clock  (clock),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop and compare one expected result each time done rises
  always @(negedge clock) begin
    exp_t e;
    if (!reset && io_out[6] && !done_prev) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(io_out[6]), 32'd0);
      end else begin
        e = sb.pop_front();
        check("quot", 32'(io_out[2:0]), 32'(e.q));
        check("rem", 32'(io_out[5:3]), 32'(e.r));
        check("div_by_zero", 32'(io_out[7]), 32'(e.dbz));
        check("latency", 32'(cyc - e.cyc), 32'(e.lat));
      end
    end
    done_prev = io_out[6];
  end

  // Drive a clean 0->1 start edge, push the expected result, hold start for extra cycles
  task automatic launch(input int a, input int b, input int hold);
    exp_t e;
    @(negedge clock);
    io_in[2:0] = a[2:0];
    io_in[5:3] = b[2:0];
    io_in[6]   = 1'b0;
    @(negedge clock);
    io_in[6] = 1'b1;
    @(posedge clock);
    #1;
    if (b == 0) begin
      e.q = 7; e.r = a; e.dbz = 1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 0; e.lat = 3;
    end
    e.cyc = cyc;
    sb.push_back(e);
    check("launch_status_clear", 32'(io_out[7:6]), 32'd0);
    repeat (hold) @(negedge clock);
    @(negedge clock);
    io_in[6] = 1'b0;
  endtask

  // Wait (bounded) until every queued result has been observed
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clock);
      #6;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    io_in = 8'h40;

    // Reset state, with start held high through reset release
    repeat (3) @(negedge clock);
    check("reset_out", 32'(io_out), 32'd0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("start_high_after_reset", 32'(io_out), 32'd0);
    end
    io_in[6] = 1'b0;
    @(negedge clock);

    // 7/2 and hold while operand pins wander
    launch(7, 2, 0);
    drain();
    repeat (20) begin
      @(negedge clock);
      io_in[5:0] = 6'($urandom_range(0, 63));
      io_in[7]   = 1'($urandom_range(0, 1));
      check("hold_out", 32'(io_out), 32'({1'b0, 1'b1, 3'd1, 3'd3}));
    end
    io_in[7] = 1'b0;

    // Back-to-back runs
    launch(6, 3, 0);
    drain();
    launch(2, 5, 0);
    drain();

    // Divide by zero, then a normal run clears the flag
    launch(5, 0, 0);
    drain();
    repeat (3) begin
      @(negedge clock);
      check("dbz_hold", 32'(io_out), 32'({1'b1, 1'b1, 3'd5, 3'd7}));
    end
    launch(5, 1, 0);
    drain();

    // Exhaustive non-zero divisors
    for (int a = 0; a < 8; a++) begin
      for (int b = 1; b < 8; b++) begin
        launch(a, b, 0);
        drain();
      end
    end

    // Start held high through RUN and beyond produces a single launch
    launch(6, 2, 12);
    drain();
    repeat (3) begin
      @(negedge clock);
      check("held_start_no_relaunch", 32'(io_out), 32'({1'b0, 1'b1, 3'd0, 3'd3}));
    end

    // A fresh start edge during RUN is ignored
    launch(3, 1, 0);
    @(negedge clock);
    io_in[2:0] = 3'd1;
    io_in[5:3] = 3'd2;
    io_in[6]   = 1'b1;
    @(negedge clock);
    io_in[6] = 1'b0;
    drain();

    // Reset mid-run discards the division
    launch(7, 1, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrun_reset_out", 32'(io_out), 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("after_reset_idle", 32'(io_out), 32'd0);
    end
    launch(7, 1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
